// File: rtl/tl_channel_buffer.sv
// TileLink channel buffer: independent A (master -> widget) and D
// (widget -> master) queues.  Every ready/valid seen at a port comes
// straight from a flop, so there is no combinational path through the
// buffer in either direction.

// Generic queue used for both channels.
// Any DEPTH from 1 to 8 works, power of two or not.
module tl_channel_buffer_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             enq_ready_r;
  logic             deq_valid_r;
  logic             enq_fire_s;
  logic             deq_fire_s;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign enq_fire_s = enq_valid & enq_ready_r;
  assign deq_fire_s = deq_valid_r & deq_ready;
  assign enq_ready  = enq_ready_r;
  assign deq_valid  = deq_valid_r;
  assign deq_bits   = mem_r[rd_ptr_r];

  // Occupancy after this cycle's transfers.
  // The count is unchanged when both sides fire or neither does.
  always_comb begin
    count_next_s = count_r;
    case ({enq_fire_s, deq_fire_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Payload storage; deliberately not reset, stale slots are never presented.
  always_ff @(posedge clock) begin
    if (enq_fire_s) begin
      mem_r[wr_ptr_r] <= enq_bits;
    end
  end

  // Pointers, count and the registered ready/valid flags.
  // The flags are held low while reset is asserted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      enq_ready_r <= 1'b0;
      deq_valid_r <= 1'b0;
    end else begin
      if (enq_fire_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (deq_fire_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r     <= count_next_s;
      enq_ready_r <= (count_next_s != CNT_W'(DEPTH));
      deq_valid_r <= (count_next_s != CNT_W'(0));
    end
  end
endmodule

// Top level: packs the TileLink fields into one entry per channel.
module tl_channel_buffer #(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [3:0]  auto_in_a_bits_size,
  input  logic [3:0]  auto_in_a_bits_source,
  input  logic [30:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [3:0]  auto_in_d_bits_size,
  output logic [3:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt,
  input  logic        auto_out_a_ready,
  output logic        auto_out_a_valid,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [3:0]  auto_out_a_bits_size,
  output logic [3:0]  auto_out_a_bits_source,
  output logic [30:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  output logic        auto_out_d_ready,
  input  logic        auto_out_d_valid,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_param,
  input  logic [3:0]  auto_out_d_bits_size,
  input  logic [3:0]  auto_out_d_bits_source,
  input  logic        auto_out_d_bits_sink,
  input  logic        auto_out_d_bits_denied,
  input  logic [63:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt
);
  localparam int A_W = 118;
  localparam int D_W = 80;

  logic [A_W-1:0] a_enq_bits_s;
  logic [A_W-1:0] a_deq_bits_s;
  logic [D_W-1:0] d_enq_bits_s;
  logic [D_W-1:0] d_deq_bits_s;

  assign a_enq_bits_s = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                         auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                         auto_in_a_bits_data, auto_in_a_bits_corrupt};
  assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
          auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
          auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_deq_bits_s;

  assign d_enq_bits_s = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                         auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                         auto_out_d_bits_data, auto_out_d_bits_corrupt};
  assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
          auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
          auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_deq_bits_s;

  tl_channel_buffer_fifo #(.WIDTH(A_W), .DEPTH(A_DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_in_a_valid),
    .enq_ready (auto_in_a_ready),
    .enq_bits  (a_enq_bits_s),
    .deq_valid (auto_out_a_valid),
    .deq_ready (auto_out_a_ready),
    .deq_bits  (a_deq_bits_s)
  );

  tl_channel_buffer_fifo #(.WIDTH(D_W), .DEPTH(D_DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_out_d_valid),
    .enq_ready (auto_out_d_ready),
    .enq_bits  (d_enq_bits_s),
    .deq_valid (auto_in_d_valid),
    .deq_ready (auto_in_d_ready),
    .deq_bits  (d_deq_bits_s)
  );
endmodule

// File: tb/tb_tl_channel_buffer.sv
// Directed bench for tl_channel_buffer: a default-depth instance plus an
// A_DEPTH=3 instance used for the pointer-wrap run.
module tb_tl_channel_buffer;
  logic clock;
  logic reset;

  // Default instance stimulus and observation buses
  logic         a_in_valid, a_out_ready, d_out_valid, d_in_ready;
  logic [117:0] a_in;
  logic [79:0]  d_out;
  wire          a_in_ready, a_out_valid, d_out_ready, d_in_valid;
  wire  [117:0] a_out;
  wire  [79:0]  d_in;

  // A_DEPTH=3 instance
  logic         a3_in_valid, a3_out_ready;
  logic [117:0] a3_in;
  logic [79:0]  d3_out;
  wire          a3_in_ready, a3_out_valid, d3_out_ready, d3_in_valid;
  wire  [117:0] a3_out;
  wire  [79:0]  d3_in;

  int n_cmp = 0;
  int n_err = 0;

  tl_channel_buffer dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(a_in_ready), .auto_in_a_valid(a_in_valid),
    .auto_in_a_bits_opcode(a_in[117:115]), .auto_in_a_bits_param(a_in[114:112]),
    .auto_in_a_bits_size(a_in[111:108]), .auto_in_a_bits_source(a_in[107:104]),
    .auto_in_a_bits_address(a_in[103:73]), .auto_in_a_bits_mask(a_in[72:65]),
    .auto_in_a_bits_data(a_in[64:1]), .auto_in_a_bits_corrupt(a_in[0]),
    .auto_in_d_ready(d_in_ready), .auto_in_d_valid(d_in_valid),
    .auto_in_d_bits_opcode(d_in[79:77]), .auto_in_d_bits_param(d_in[76:75]),
    .auto_in_d_bits_size(d_in[74:71]), .auto_in_d_bits_source(d_in[70:67]),
    .auto_in_d_bits_sink(d_in[66]), .auto_in_d_bits_denied(d_in[65]),
    .auto_in_d_bits_data(d_in[64:1]), .auto_in_d_bits_corrupt(d_in[0]),
    .auto_out_a_ready(a_out_ready), .auto_out_a_valid(a_out_valid),
    .auto_out_a_bits_opcode(a_out[117:115]), .auto_out_a_bits_param(a_out[114:112]),
    .auto_out_a_bits_size(a_out[111:108]), .auto_out_a_bits_source(a_out[107:104]),
    .auto_out_a_bits_address(a_out[103:73]), .auto_out_a_bits_mask(a_out[72:65]),
    .auto_out_a_bits_data(a_out[64:1]), .auto_out_a_bits_corrupt(a_out[0]),
    .auto_out_d_ready(d_out_ready), .auto_out_d_valid(d_out_valid),
    .auto_out_d_bits_opcode(d_out[79:77]), .auto_out_d_bits_param(d_out[76:75]),
    .auto_out_d_bits_size(d_out[74:71]), .auto_out_d_bits_source(d_out[70:67]),
    .auto_out_d_bits_sink(d_out[66]), .auto_out_d_bits_denied(d_out[65]),
    .auto_out_d_bits_data(d_out[64:1]), .auto_out_d_bits_corrupt(d_out[0])
  );

  tl_channel_buffer #(.A_DEPTH(3)) dut3 (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(a3_in_ready), .auto_in_a_valid(a3_in_valid),
    .auto_in_a_bits_opcode(a3_in[117:115]), .auto_in_a_bits_param(a3_in[114:112]),
    .auto_in_a_bits_size(a3_in[111:108]), .auto_in_a_bits_source(a3_in[107:104]),
    .auto_in_a_bits_address(a3_in[103:73]), .auto_in_a_bits_mask(a3_in[72:65]),
    .auto_in_a_bits_data(a3_in[64:1]), .auto_in_a_bits_corrupt(a3_in[0]),
    .auto_in_d_ready(1'b0), .auto_in_d_valid(d3_in_valid),
    .auto_in_d_bits_opcode(d3_in[79:77]), .auto_in_d_bits_param(d3_in[76:75]),
    .auto_in_d_bits_size(d3_in[74:71]), .auto_in_d_bits_source(d3_in[70:67]),
    .auto_in_d_bits_sink(d3_in[66]), .auto_in_d_bits_denied(d3_in[65]),
    .auto_in_d_bits_data(d3_in[64:1]), .auto_in_d_bits_corrupt(d3_in[0]),
    .auto_out_a_ready(a3_out_ready), .auto_out_a_valid(a3_out_valid),
    .auto_out_a_bits_opcode(a3_out[117:115]), .auto_out_a_bits_param(a3_out[114:112]),
    .auto_out_a_bits_size(a3_out[111:108]), .auto_out_a_bits_source(a3_out[107:104]),
    .auto_out_a_bits_address(a3_out[103:73]), .auto_out_a_bits_mask(a3_out[72:65]),
    .auto_out_a_bits_data(a3_out[64:1]), .auto_out_a_bits_corrupt(a3_out[0]),
    .auto_out_d_ready(d3_out_ready), .auto_out_d_valid(1'b0),
    .auto_out_d_bits_opcode(d3_out[79:77]), .auto_out_d_bits_param(d3_out[76:75]),
    .auto_out_d_bits_size(d3_out[74:71]), .auto_out_d_bits_source(d3_out[70:67]),
    .auto_out_d_bits_sink(d3_out[66]), .auto_out_d_bits_denied(d3_out[65]),
    .auto_out_d_bits_data(d3_out[64:1]), .auto_out_d_bits_corrupt(d3_out[0])
  );

  // Free-running clock, 10 time units per cycle
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A beat whose every field is a function of source and data
  function automatic logic [117:0] a_pack(input logic [3:0] src, input logic [63:0] d);
    return {d[2:0], d[5:3], d[9:6], src, d[40:10], d[48:41], d, d[0] ^ src[0]};
  endfunction

  // D beat with explicit denied/corrupt
  function automatic logic [79:0] d_pack(input logic [3:0] src, input logic [63:0] d,
                                         input logic den, input logic cor);
    return {d[2:0], d[4:3], d[8:5], src, d[9], den, d, cor};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable afterwards
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int sent, recv, cnt;
    logic in_f, out_f;
    reset = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; d_out_valid = 1'b0; d_in_ready = 1'b0;
    a_in = '0; d_out = '0;
    a3_in_valid = 1'b0; a3_out_ready = 1'b0; a3_in = '0; d3_out = '0;

    // ---- reset state and first edge after release
    #2;
    check("rst_a_ready", a_in_ready, 1'b0);
    check("rst_d_ready", d_out_ready, 1'b0);
    check("rst_valids", {a_out_valid, d_in_valid}, 2'b00);
    tick(); tick();
    check("rst_hold", {a_in_ready, d_out_ready, a_out_valid, d_in_valid}, 4'b0000);
    reset = 1'b1;
    tick();
    check("rel_readies", {a_in_ready, d_out_ready}, 2'b11);
    check("rel_valids", {a_out_valid, d_in_valid}, 2'b00);
    check("rel_d3", {a3_in_ready, d3_out_ready, a3_out_valid, d3_in_valid}, 4'b1100);

    // ---- A backpressure: two accepted, third held until downstream drains
    a_in_valid = 1'b1; a_in = a_pack(4'd1, 64'hDEAD_BEEF_0123_4561);
    tick();
    check("bp_e1_ready", a_in_ready, 1'b1);
    check("bp_e1_bits", {a_out_valid, a_out}, {1'b1, a_pack(4'd1, 64'hDEAD_BEEF_0123_4561)});
    a_in = a_pack(4'd2, 64'hCAFE_F00D_89AB_CDE2);
    tick();
    check("bp_full_ready", a_in_ready, 1'b0);
    a_in = a_pack(4'd3, 64'h5555_AAAA_3333_CCC3);
    tick();
    check("bp_held_ready", a_in_ready, 1'b0);
    check("bp_held_bits", {a_out_valid, a_out}, {1'b1, a_pack(4'd1, 64'hDEAD_BEEF_0123_4561)});
    a_out_ready = 1'b1;
    tick();
    check("bp_out2", {a_out_valid, a_out}, {1'b1, a_pack(4'd2, 64'hCAFE_F00D_89AB_CDE2)});
    check("bp_reopen", a_in_ready, 1'b1);
    tick();
    check("bp_out3", {a_out_valid, a_out}, {1'b1, a_pack(4'd3, 64'h5555_AAAA_3333_CCC3)});
    a_in_valid = 1'b0;
    tick();
    check("bp_empty", a_out_valid, 1'b0);

    // ---- A streaming, 100 beats, one per cycle after one cycle of latency
    for (int k = 0; k < 100; k++) begin
      a_in_valid = 1'b1; a_in = a_pack(k[3:0], 64'(k));
      tick();
      check("stream_beat", {a_in_ready, a_out_valid, a_out}, {2'b11, a_pack(k[3:0], 64'(k))});
    end
    a_in_valid = 1'b0;
    tick();
    check("stream_drained", a_out_valid, 1'b0);
    a_out_ready = 1'b0;

    // ---- D full, same-cycle dequeue and enqueue offer
    d_out_valid = 1'b1; d_out = d_pack(4'd4, 64'h1111_2222_3333_0004, 1'b0, 1'b0);
    tick();
    d_out = d_pack(4'd5, 64'h4444_5555_6666_0205, 1'b1, 1'b1);
    tick();
    check("d_full_ready", d_out_ready, 1'b0);
    check("d_head0", {d_in_valid, d_in}, {1'b1, d_pack(4'd4, 64'h1111_2222_3333_0004, 1'b0, 1'b0)});
    d_in_ready = 1'b1; d_out = d_pack(4'd6, 64'h7777_8888_9999_03A6, 1'b0, 1'b1);
    tick();
    check("d_head1", {d_in_valid, d_in}, {1'b1, d_pack(4'd5, 64'h4444_5555_6666_0205, 1'b1, 1'b1)});
    check("d_reopen", d_out_ready, 1'b1);
    tick();
    check("d_head2", {d_in_valid, d_in}, {1'b1, d_pack(4'd6, 64'h7777_8888_9999_03A6, 1'b0, 1'b1)});
    d_out_valid = 1'b0;
    tick();
    check("d_empty", d_in_valid, 1'b0);
    d_in_ready = 1'b0;

    // ---- mid-operation reset with both queues full
    a_in_valid = 1'b1; d_out_valid = 1'b1;
    a_in = a_pack(4'd9, 64'h9); d_out = d_pack(4'd9, 64'h9, 1'b1, 1'b0);
    tick(); tick();
    a_in_valid = 1'b0; d_out_valid = 1'b0;
    check("mr_loaded", {a_out_valid, d_in_valid, a_in_ready, d_out_ready}, 4'b1100);
    reset = 1'b0;
    #1;
    check("mr_async", {a_out_valid, d_in_valid, a_in_ready, d_out_ready}, 4'b0000);
    tick();
    reset = 1'b1; a_out_ready = 1'b1; d_in_ready = 1'b1;
    tick();
    check("mr_after1", {a_out_valid, d_in_valid, a_in_ready, d_out_ready}, 4'b0011);
    tick();
    check("mr_after2", {a_out_valid, d_in_valid}, 2'b00);
    a_out_ready = 1'b0; d_in_ready = 1'b0;

    // ---- A_DEPTH=3 with stalls on both sides: wrap 2 -> 0 several times
    sent = 0; recv = 0; cnt = 0;
    for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
      a3_in_valid  = (sent < 10) && ((cyc % 5) != 2);
      a3_in        = a_pack(sent[3:0], 64'hA000_0000_0000_0000 | 64'(sent * 7 + 1));
      a3_out_ready = ((cyc % 3) == 0) || (cyc >= 20);
      check("w_ready", a3_in_ready, (cnt != 3));
      check("w_valid", a3_out_valid, (cnt != 0));
      in_f  = a3_in_valid && (cnt != 3);
      out_f = (cnt != 0) && a3_out_ready;
      if (out_f) begin
        check("w_data", a3_out, a_pack(recv[3:0], 64'hA000_0000_0000_0000 | 64'(recv * 7 + 1)));
        recv++;
      end
      if (in_f) sent++;
      cnt = cnt + (in_f ? 1 : 0) - (out_f ? 1 : 0);
      tick();
    end
    check("w_total", 32'(recv), 32'd10);
    check("w_d3_idle", {d3_in_valid, d3_in[0]}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
